// File: rtl/fsbm_pkg.sv
// Shared types for the full-search block matcher.
// Candidate bundle, FSM encoding and default widths.
package fsbm_pkg;

    localparam int SAD_W = 12;
    localparam int MV_W  = 4;
    localparam int ROWS  = 16;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  mvx;
        logic [MV_W-1:0]  mvy;
    } mv_cand_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/mv_min2.sv
// Two-way candidate minimum, unsigned SAD compare.
// A tie keeps operand a, so the earlier row wins.
module mv_min2
    import fsbm_pkg::*;
(
    input  mv_cand_t a,
    input  mv_cand_t b,
    output mv_cand_t y
);

    assign y = (b.sad < a.sad) ? b : a;

endmodule

// File: rtl/mv_best_select.sv
// Global-minimum motion vector over ROWS row candidates.
// Define MV_BLK_CNT_EN to expose an 8-bit block index on out_blk.
module mv_best_select #(
    parameter int SAD_W = fsbm_pkg::SAD_W,
    parameter int MV_W  = fsbm_pkg::MV_W,
    parameter int ROWS  = fsbm_pkg::ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SAD_W-1:0] in_sad,
    input  logic [MV_W-1:0]  in_mvx,
    input  logic [MV_W-1:0]  in_mvy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SAD_W-1:0] out_sad,
    output logic [MV_W-1:0]  out_mvx,
    output logic [MV_W-1:0]  out_mvy,
    output logic [7:0]       out_blk
);

    import fsbm_pkg::*;

    localparam int CNT_W = $clog2(ROWS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);

    state_t     state_q;
    state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    mv_cand_t   best_q;
    mv_cand_t   best_d;
    mv_cand_t   cand;
    mv_cand_t   pick;
    mv_cand_t   res_q;
    logic       res_v_q;
    logic       res_ld;
    logic       last;
    logic       accept;

    always_comb begin
        cand.sad = in_sad;
        cand.mvx = in_mvx;
        cand.mvy = in_mvy;
    end

    mv_min2 u_min2 (
        .a (best_q),
        .b (cand),
        .y (pick)
    );

    assign last     = (cnt_q == LAST);
    assign in_ready = !last || !res_v_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ACC;
            ACC:  if (accept && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        best_d = best_q;
        cnt_d  = cnt_q;
        res_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    best_d = cand;
                    cnt_d  = CNT_W'(1);
                end
            end
            ACC: begin
                if (accept) begin
                    if (last) begin
                        res_ld = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        best_d = pick;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            best_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            best_q <= best_d;
        end
    end

    // A new result may load in the same cycle the old one is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            res_v_q <= 1'b0;
        end else if (res_ld) begin
            res_q   <= pick;
            res_v_q <= 1'b1;
        end else if (res_v_q && out_ready) begin
            res_v_q <= 1'b0;
        end
    end

    assign out_valid = res_v_q;
    assign out_sad   = res_q.sad;
    assign out_mvx   = res_q.mvx;
    assign out_mvy   = res_q.mvy;

`ifdef MV_BLK_CNT_EN
    logic [7:0] blk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= '0;
        end else if (res_v_q && out_ready) begin
            blk_q <= blk_q + 8'd1;
        end
    end

    assign out_blk = blk_q;
`else
    assign out_blk = 8'd0;
`endif

endmodule

// File: tb/tb_mv_best_select.sv
// Directed bench for mv_best_select.
// Block vectors with hand-computed minima plus stall/reset sequences.
module tb_mv_best_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_sad;
    logic [3:0]  in_mvx;
    logic [3:0]  in_mvy;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sad;
    logic [3:0]  out_mvx;
    logic [3:0]  out_mvy;
    logic [7:0]  out_blk;

    mv_best_select dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sad    (in_sad),
        .in_mvx    (in_mvx),
        .in_mvy    (in_mvy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad),
        .out_mvx   (out_mvx),
        .out_mvy   (out_mvy),
        .out_blk   (out_blk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][11:0] sad;
        logic [15:0][3:0]  mvx;
        logic [11:0]       e_sad;
        logic [3:0]        e_mvx;
        logic [3:0]        e_mvy;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_bad = 0;
    int blk_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] blk_ref();
`ifdef MV_BLK_CNT_EN
        return 8'(blk_exp);
`else
        return 8'd0;
`endif
    endfunction

    task automatic push(input logic [11:0] s, input logic [3:0] x,
                        input logic [3:0] y);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sad   = s;
        in_mvx   = x;
        in_mvy   = y;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_result(input int v);
        chk("res_valid", 32'(out_valid), 1);
        chk("res_sad", 32'(out_sad), 32'(tbl[v].e_sad));
        chk("res_mvx", 32'(out_mvx), 32'(tbl[v].e_mvx));
        chk("res_mvy", 32'(out_mvy), 32'(tbl[v].e_mvy));
        chk("res_blk", 32'(out_blk), 32'(blk_ref()));
    endtask

    task automatic run_block(input int v, input bit gaps);
        for (int r = 0; r < 16; r++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            push(tbl[v].sad[r], tbl[v].mvx[r], 4'(r));
            if (r == 14) chk("early_valid", 32'(out_valid), 0);
        end
        check_result(v);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drained", 32'(out_valid), 0);
        blk_exp++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[0].sad[i] = 12'(100 - i);
            tbl[0].mvx[i] = 4'(i);
            tbl[1].sad[i] = 12'd50;
            tbl[1].mvx[i] = 4'(15 - i);
            tbl[2].sad[i] = (i == 9) ? 12'd3 : 12'd200;
            tbl[2].mvx[i] = 4'(i ^ 5);
            tbl[3].sad[i] = (i == 15) ? 12'd4094 : 12'd4095;
            tbl[3].mvx[i] = 4'(i);
            tbl[4].sad[i] = 12'(i * 7);
            tbl[4].mvx[i] = 4'd3;
            tbl[5].sad[i] = (i == 5) ? 12'd2047 : 12'd2048;
            tbl[5].mvx[i] = 4'(i);
            tbl[6].sad[i] = (i == 3 || i == 11) ? 12'd10 : 12'd20;
            tbl[6].mvx[i] = 4'(i);
        end
        tbl[0].e_sad = 85;   tbl[0].e_mvx = 15; tbl[0].e_mvy = 15;
        tbl[1].e_sad = 50;   tbl[1].e_mvx = 15; tbl[1].e_mvy = 0;
        tbl[2].e_sad = 3;    tbl[2].e_mvx = 12; tbl[2].e_mvy = 9;
        tbl[3].e_sad = 4094; tbl[3].e_mvx = 15; tbl[3].e_mvy = 15;
        tbl[4].e_sad = 0;    tbl[4].e_mvx = 3;  tbl[4].e_mvy = 0;
        tbl[5].e_sad = 2047; tbl[5].e_mvx = 5;  tbl[5].e_mvy = 5;
        tbl[6].e_sad = 10;   tbl[6].e_mvx = 3;  tbl[6].e_mvy = 3;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sad    = '0;
        in_mvx    = '0;
        in_mvy    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sad", 32'(out_sad), 0);
        chk("rst_mvx", 32'(out_mvx), 0);
        chk("rst_mvy", 32'(out_mvy), 0);
        chk("rst_blk", 32'(out_blk), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            run_block(v, 1'b0);
            drain();
        end

        // Stalled last row, then handshake and last-row accept together.
        @(negedge clk);
        out_ready = 1'b0;
        run_block(0, 1'b0);
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sad   = tbl[2].sad[r];
            in_mvx   = tbl[2].mvx[r];
            in_mvy   = 4'(r);
            #1;
            chk("nonlast_ready", 32'(in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        chk("held_valid", 32'(out_valid), 1);
        chk("held_sad", 32'(out_sad), 85);
        @(negedge clk);
        in_valid = 1'b1;
        in_sad   = tbl[2].sad[15];
        in_mvx   = tbl[2].mvx[15];
        in_mvy   = 4'd15;
        #1;
        chk("last_stall", 32'(in_ready), 0);
        @(negedge clk);
        chk("last_stall2", 32'(in_ready), 0);
        chk("held_mvx", 32'(out_mvx), 15);
        out_ready = 1'b1;
        #1;
        chk("last_release", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        blk_exp++;
        check_result(2);
        @(posedge clk);
        #1;
        chk("drained_sim", 32'(out_valid), 0);
        blk_exp++;

        // Reset in the middle of a block with a result pending.
        @(negedge clk);
        out_ready = 1'b0;
        run_block(0, 1'b0);
        for (int r = 0; r < 8; r++) push(12'd1, 4'd7, 4'(r));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sad", 32'(out_sad), 0);
        chk("mid_rst_mvx", 32'(out_mvx), 0);
        chk("mid_rst_mvy", 32'(out_mvy), 0);
        chk("mid_rst_blk", 32'(out_blk), 0);
        blk_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        run_block(2, 1'b0);
        drain();

        for (int v = 3; v < 6; v++) begin
            run_block(v, 1'b1);
            drain();
        end

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        blk_exp = 0;
        for (int b = 0; b < 257; b++) begin
            run_block(b % NV, 1'b0);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
